// File: rtl/fft_frame_streamer.sv
// -----------------------------------------------------------------------------
// fft_frame_streamer
//
// Frame controller between the ADC sample FIFO, the FFT IP and the byte-wide
// UART transmitter. Pulls N_POINTS samples from a show-ahead FIFO and streams
// them to the FFT over AXI4-Stream with tlast on the final beat. Captures the
// complex result frame in an internal buffer, then sends it over the UART as
// a packet: A5 5A <frame_cnt> <payload, MSB byte of point 0 first> <xor csum>.
// Supports single-shot and continuous (auto re-arm) operation.
//
// Ports:
//   clk_24M_from_pll          processing clock
//   rst_24M_n                 asynchronous active-low reset
//   i_start                   start pulse, honoured only in IDLE
//   i_continuous              re-arm after each frame when 1
//   i_stop                    clears continuous mode, current frame completes
//   i_smp_data / i_smp_empty  show-ahead FIFO head word / empty flag
//   o_smp_rd_en               FIFO pop, one per word loaded towards the FFT
//   o_fft_tvalid/tdata/tlast  AXI-S master to the FFT input
//   i_fft_tready              FFT input ready
//   i_fft_m_tvalid/tdata/tlast  FFT result stream (no backpressure)
//   o_uart_data / o_uart_start  byte to send / one-cycle send pulse
//   i_uart_busy               transmitter busy (rises the cycle after start)
//   o_busy                    high whenever not IDLE
//   o_frame_cnt               completed frames, wraps 255 -> 0
//   o_err_len                 sticky result-length error, cleared by i_start
// -----------------------------------------------------------------------------
module fft_frame_streamer #(
    parameter int N_POINTS   = 1024,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 48,
    parameter int OFFSET_BIN = 1
) (
    input  logic              clk_24M_from_pll,
    input  logic              rst_24M_n,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_stop,
    input  logic [IN_W-1:0]   i_smp_data,
    input  logic              i_smp_empty,
    output logic              o_smp_rd_en,
    output logic              o_fft_tvalid,
    output logic [IN_W-1:0]   o_fft_tdata,
    output logic              o_fft_tlast,
    input  logic              i_fft_tready,
    input  logic              i_fft_m_tvalid,
    input  logic [OUT_W-1:0]  i_fft_m_tdata,
    input  logic              i_fft_m_tlast,
    output logic [7:0]        o_uart_data,
    output logic              o_uart_start,
    input  logic              i_uart_busy,
    output logic              o_busy,
    output logic [7:0]        o_frame_cnt,
    output logic              o_err_len
);

    localparam int NB = OUT_W / 8;
    localparam int AW = $clog2(N_POINTS);
    localparam int CW = AW + 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [CW-1:0] LAST_PT   = CW'(N_POINTS - 1);
    localparam logic [CW-1:0] NPTS      = CW'(N_POINTS);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_STORE,
        S_HDR,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t state_reg, state_next;

    logic            cont_reg;
    logic [CW-1:0]   in_cnt_reg;
    logic [CW-1:0]   out_cnt_reg;
    logic [CW-1:0]   pt_cnt_reg;
    logic [BW-1:0]   byte_idx_reg;
    logic [1:0]      hdr_idx_reg;
    logic [7:0]      csum_reg;
    logic            start_d1_reg;
    logic [OUT_W-1:0] rd_word_reg;

    logic [OUT_W-1:0] buf_mem [N_POINTS];

    logic            load;
    logic            fft_last_hs;
    logic            can_issue;
    logic            issue;
    logic [7:0]      issue_byte;
    logic            store_beat;
    logic            store_done;
    logic            store_err;
    logic            frame_start;
    logic [IN_W-1:0] smp_conv;
    logic [BW-1:0]   byte_sel;
    logic [OUT_W-1:0] word_shift;
    logic [7:0]      payload_byte;

    // Sign-bit flip turns offset-binary ADC codes into two's complement.
    generate
        if (OFFSET_BIN != 0) begin : g_offset_bin
            assign smp_conv = {~i_smp_data[IN_W-1], i_smp_data[IN_W-2:0]};
        end else begin : g_twos_comp
            assign smp_conv = i_smp_data;
        end
    endgenerate

    // Output register may take a new word when it is empty or being drained.
    assign load = (state_reg == S_FEED) && (!o_fft_tvalid || i_fft_tready)
                  && !i_smp_empty && (in_cnt_reg < NPTS);
    assign o_smp_rd_en = load;
    assign fft_last_hs = o_fft_tvalid && i_fft_tready && o_fft_tlast;

    // Busy only rises the cycle after a start, so the last two issued starts
    // also block a new one.
    assign can_issue = !i_uart_busy && !o_uart_start && !start_d1_reg;

    assign store_beat = (state_reg == S_STORE) && i_fft_m_tvalid;
    assign store_done = store_beat && (i_fft_m_tlast || (out_cnt_reg == LAST_PT));
    assign store_err  = store_beat && (i_fft_m_tlast ? (out_cnt_reg != LAST_PT)
                                                     : (out_cnt_reg == LAST_PT));

    // MSB byte of each point goes out first.
    assign byte_sel     = LAST_BYTE - byte_idx_reg;
    assign word_shift   = rd_word_reg >> {byte_sel, 3'b000};
    assign payload_byte = word_shift[7:0];

    assign o_busy = (state_reg != S_IDLE);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        issue_byte = 8'h00;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_FEED;
                end
            end
            S_FEED: begin
                if (fft_last_hs) begin
                    state_next = S_STORE;
                end
            end
            S_STORE: begin
                if (store_done) begin
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                issue = can_issue;
                case (hdr_idx_reg)
                    2'd0:    issue_byte = 8'hA5;
                    2'd1:    issue_byte = 8'h5A;
                    default: issue_byte = o_frame_cnt;
                endcase
                if (can_issue && (hdr_idx_reg == 2'd2)) begin
                    state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                issue      = can_issue;
                issue_byte = payload_byte;
                if (can_issue && (pt_cnt_reg == LAST_PT) && (byte_idx_reg == LAST_BYTE)) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                issue      = can_issue;
                issue_byte = csum_reg;
                if (can_issue) begin
                    // A stop in the same cycle as the re-arm decision wins.
                    state_next = (cont_reg && i_continuous && !i_stop) ? S_FEED : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign frame_start = ((state_reg == S_IDLE) && i_start)
                         || ((state_reg == S_CSUM) && (state_next == S_FEED));

    always_ff @(posedge clk_24M_from_pll or negedge rst_24M_n) begin
        if (!rst_24M_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_24M_from_pll or negedge rst_24M_n) begin
        if (!rst_24M_n) begin
            cont_reg     <= 1'b0;
            in_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            pt_cnt_reg   <= '0;
            byte_idx_reg <= '0;
            hdr_idx_reg  <= '0;
            csum_reg     <= '0;
            start_d1_reg <= 1'b0;
            o_fft_tvalid <= 1'b0;
            o_fft_tdata  <= '0;
            o_fft_tlast  <= 1'b0;
            o_uart_data  <= '0;
            o_uart_start <= 1'b0;
            o_frame_cnt  <= '0;
            o_err_len    <= 1'b0;
        end else begin
            o_uart_start <= issue;
            start_d1_reg <= o_uart_start;
            if (issue) begin
                o_uart_data <= issue_byte;
            end

            // Continuous flag: latched at start, dropped at a frame end without
            // i_continuous, and cleared by stop with highest priority.
            if ((state_reg == S_IDLE) && i_start) begin
                cont_reg <= i_continuous;
            end
            if ((state_reg == S_CSUM) && can_issue) begin
                cont_reg <= cont_reg && i_continuous;
            end
            if (i_stop) begin
                cont_reg <= 1'b0;
            end

            if ((state_reg == S_IDLE) && i_start) begin
                o_err_len <= 1'b0;
            end else if (store_err) begin
                o_err_len <= 1'b1;
            end

            if (frame_start) begin
                in_cnt_reg   <= '0;
                out_cnt_reg  <= '0;
                pt_cnt_reg   <= '0;
                byte_idx_reg <= '0;
                hdr_idx_reg  <= '0;
            end

            // AXI-S output register: hold while stalled, drop valid once drained.
            if (load) begin
                o_fft_tdata  <= smp_conv;
                o_fft_tvalid <= 1'b1;
                o_fft_tlast  <= (in_cnt_reg == LAST_PT);
                in_cnt_reg   <= in_cnt_reg + 1'b1;
            end else if (i_fft_tready) begin
                o_fft_tvalid <= 1'b0;
                o_fft_tlast  <= 1'b0;
            end

            if (store_beat) begin
                out_cnt_reg <= out_cnt_reg + 1'b1;
            end
            if (store_done) begin
                csum_reg    <= '0;
                hdr_idx_reg <= '0;
            end

            if ((state_reg == S_HDR) && issue) begin
                hdr_idx_reg <= hdr_idx_reg + 1'b1;
            end

            if ((state_reg == S_PAYLOAD) && issue) begin
                csum_reg <= csum_reg ^ payload_byte;
                if (byte_idx_reg == LAST_BYTE) begin
                    byte_idx_reg <= '0;
                    pt_cnt_reg   <= pt_cnt_reg + 1'b1;
                end else begin
                    byte_idx_reg <= byte_idx_reg + 1'b1;
                end
            end

            if ((state_reg == S_CSUM) && issue) begin
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
        end
    end

    // Result buffer: plain array with registered read so it maps to block RAM.
    // The read address only moves after a byte is issued and the issue guard
    // spaces starts by at least three cycles, so rd_word_reg is always current.
    always_ff @(posedge clk_24M_from_pll) begin
        if (store_beat) begin
            buf_mem[out_cnt_reg[AW-1:0]] <= i_fft_m_tdata;
        end
        rd_word_reg <= buf_mem[pt_cnt_reg[AW-1:0]];
    end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// -----------------------------------------------------------------------------
// Testbench for fft_frame_streamer (N_POINTS=8, 8-bit samples, 48-bit results).
// Agents: show-ahead FIFO + tready driver, FFT result generator, UART busy
// model. Expected FFT input beats and UART bytes are queued when stimulus is
// produced; independent monitors pop and compare whenever the DUT presents
// a handshake or a UART start.
// -----------------------------------------------------------------------------
module tb_fft_frame_streamer;

    localparam int N     = 8;
    localparam int IN_W  = 8;
    localparam int OUT_W = 48;
    localparam int NB    = OUT_W / 8;
    localparam int PKT   = N * NB + 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_continuous = 1'b0;
    logic              i_stop = 1'b0;
    logic [IN_W-1:0]   i_smp_data = '0;
    logic              i_smp_empty = 1'b1;
    logic              o_smp_rd_en;
    logic              o_fft_tvalid;
    logic [IN_W-1:0]   o_fft_tdata;
    logic              o_fft_tlast;
    logic              i_fft_tready = 1'b1;
    logic              i_fft_m_tvalid = 1'b0;
    logic [OUT_W-1:0]  i_fft_m_tdata = '0;
    logic              i_fft_m_tlast = 1'b0;
    logic [7:0]        o_uart_data;
    logic              o_uart_start;
    logic              i_uart_busy = 1'b0;
    logic              o_busy;
    logic [7:0]        o_frame_cnt;
    logic              o_err_len;

    always #5 clk = ~clk;

    fft_frame_streamer #(
        .N_POINTS   (N),
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .OFFSET_BIN (1)
    ) dut (
        .clk_24M_from_pll (clk),
        .rst_24M_n        (rst_n),
        .i_start          (i_start),
        .i_continuous     (i_continuous),
        .i_stop           (i_stop),
        .i_smp_data       (i_smp_data),
        .i_smp_empty      (i_smp_empty),
        .o_smp_rd_en      (o_smp_rd_en),
        .o_fft_tvalid     (o_fft_tvalid),
        .o_fft_tdata      (o_fft_tdata),
        .o_fft_tlast      (o_fft_tlast),
        .i_fft_tready     (i_fft_tready),
        .i_fft_m_tvalid   (i_fft_m_tvalid),
        .i_fft_m_tdata    (i_fft_m_tdata),
        .i_fft_m_tlast    (i_fft_m_tlast),
        .o_uart_data      (o_uart_data),
        .o_uart_start     (o_uart_start),
        .i_uart_busy      (i_uart_busy),
        .o_busy           (o_busy),
        .o_frame_cnt      (o_frame_cnt),
        .o_err_len        (o_err_len)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues and reference model state.
    logic [7:0]       fifo_q   [$];
    logic [8:0]       fft_exp  [$];   // {tlast, tdata}
    logic [7:0]       uart_exp [$];
    logic [OUT_W-1:0] mbuf [N];
    int               fc_model  = 0;
    bit               err_model = 1'b0;

    // Stimulus configuration.
    int tl_idx      = N - 1;
    int n_out       = N;
    bit tready_rand = 1'b0;
    bit starve_en   = 1'b0;
    int busy_len    = 10;
    int uart_seen   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // FIFO and tready driver.
    initial begin : fifo_drv
        bit pop_pending;
        bit starve;
        int cyc;
        pop_pending = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (pop_pending && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
            end
            cyc++;
            starve = starve_en && (cyc % 3 == 0);
            i_smp_empty  = (fifo_q.size() == 0) || starve;
            i_smp_data   = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
            i_fft_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            pop_pending = o_smp_rd_en;
            if (o_smp_rd_en) begin
                chk("pop_while_empty", i_smp_empty, 1'b0);
            end
        end
    end

    // FFT input monitor: ordering, tlast position and AXI stability.
    initial begin : fft_in_mon
        bit         prev_stall;
        logic [7:0] prev_data;
        bit         prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("axi_hold_valid", o_fft_tvalid, 1'b1);
                    chk("axi_hold_data", o_fft_tdata, prev_data);
                    chk("axi_hold_last", o_fft_tlast, prev_last);
                end
                if (o_fft_tvalid && i_fft_tready) begin
                    if (fft_exp.size() == 0) begin
                        chk("fft_unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        e = fft_exp.pop_front();
                        chk("fft_tdata", o_fft_tdata, e[7:0]);
                        chk("fft_tlast", o_fft_tlast, e[8]);
                    end
                end
                prev_stall = o_fft_tvalid && !i_fft_tready;
                prev_data  = o_fft_tdata;
                prev_last  = o_fft_tlast;
            end
        end
    end

    // FFT result generator: reacts to the last input beat, computes the
    // packet the UART must emit, then plays the result beats out.
    initial begin : fft_out_model
        logic [OUT_W-1:0] beats [16];
        int   nw;
        bit   e;
        logic [7:0] cs;
        logic [7:0] bt;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && o_fft_tvalid && i_fft_tready && o_fft_tlast) begin
                for (int j = 0; j < n_out; j++) begin
                    beats[j] = OUT_W'({$urandom(), $urandom()});
                end
                nw = n_out;
                if (tl_idx < n_out) nw = tl_idx + 1;
                if (nw > N) nw = N;
                e = !((tl_idx == N - 1) && (n_out >= N));
                for (int j = 0; j < nw; j++) mbuf[j] = beats[j];
                err_model = err_model | e;
                uart_exp.push_back(8'hA5);
                uart_exp.push_back(8'h5A);
                uart_exp.push_back(8'(fc_model));
                cs = 8'h00;
                for (int p = 0; p < N; p++) begin
                    for (int b = 0; b < NB; b++) begin
                        bt = 8'(mbuf[p] >> (8 * (NB - 1 - b)));
                        uart_exp.push_back(bt);
                        cs = cs ^ bt;
                    end
                end
                uart_exp.push_back(cs);
                fc_model = (fc_model + 1) % 256;
                for (int j = 0; j < n_out; j++) begin
                    @(negedge clk);
                    while ($urandom_range(0, 3) == 0) begin
                        i_fft_m_tvalid = 1'b0;
                        i_fft_m_tlast  = 1'b0;
                        @(negedge clk);
                    end
                    i_fft_m_tvalid = 1'b1;
                    i_fft_m_tdata  = beats[j];
                    i_fft_m_tlast  = (j == tl_idx);
                end
                @(negedge clk);
                i_fft_m_tvalid = 1'b0;
                i_fft_m_tlast  = 1'b0;
            end
        end
    end

    // UART busy model and byte monitor.
    initial begin : uart_mon
        int busy_cnt;
        bit h1, h2, b1;
        logic [7:0] e;
        busy_cnt = 0;
        h1 = 1'b0; h2 = 1'b0; b1 = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                i_uart_busy = 1'b1;
                busy_cnt--;
            end else begin
                i_uart_busy = 1'b0;
            end
            #1;
            if (o_uart_start) begin
                chk("uart_pacing", {b1, h1, h2}, 3'b000);
                if (uart_exp.size() == 0) begin
                    chk("uart_unexpected_byte", 1'b1, 1'b0);
                end else begin
                    e = uart_exp.pop_front();
                    chk("uart_byte", o_uart_data, e);
                end
                uart_seen++;
                $display("uart byte %0d: 0x%02h", uart_seen, o_uart_data);
                busy_cnt = busy_len;
            end
            h2 = h1;
            h1 = o_uart_start;
            b1 = i_uart_busy;
        end
    end

    task automatic push_frame(input bit dc);
        logic [7:0] s;
        for (int i = 0; i < N; i++) begin
            s = dc ? 8'h80 : 8'($urandom);
            fifo_q.push_back(s);
            fft_exp.push_back({(i == N - 1), s ^ 8'h80});
        end
    endtask

    task automatic pulse_start(input bit cont);
        @(negedge clk);
        i_continuous = cont;
        i_start = 1'b1;
        err_model = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int  c;
        bit  done;
        c = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            @(negedge clk);
            #2;
            c++;
            done = (o_busy == 1'b0) && (uart_exp.size() == 0);
        end
        chk({nm, "_finished"}, done, 1'b1);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int c;
        c = 0;
        while (uart_seen < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("byte_progress", (uart_seen >= target), 1'b1);
    endtask

    task automatic check_frame_end(input string nm);
        chk({nm, "_frame_cnt"}, o_frame_cnt, 8'(fc_model));
        chk({nm, "_err_len"}, o_err_len, err_model);
        chk({nm, "_idle"}, o_busy, 1'b0);
        chk({nm, "_fifo_drained"}, fifo_q.size(), 0);
        chk({nm, "_all_beats_seen"}, fft_exp.size(), 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_tvalid"}, o_fft_tvalid, 1'b0);
        chk({nm, "_tdata"}, o_fft_tdata, 8'h00);
        chk({nm, "_tlast"}, o_fft_tlast, 1'b0);
        chk({nm, "_rd_en"}, o_smp_rd_en, 1'b0);
        chk({nm, "_uart_start"}, o_uart_start, 1'b0);
        chk({nm, "_uart_data"}, o_uart_data, 8'h00);
        chk({nm, "_busy"}, o_busy, 1'b0);
        chk({nm, "_frame_cnt"}, o_frame_cnt, 8'h00);
        chk({nm, "_err_len"}, o_err_len, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        uart_exp.delete();
        fc_model  = 0;
        err_model = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int base;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, DC input at mid-scale.
        tl_idx = N - 1; n_out = N;
        push_frame(1'b1);
        pulse_start(1'b0);
        wait_done("single", 3000);
        check_frame_end("single");

        // Random tready and a FIFO that runs dry every third cycle.
        tready_rand = 1'b1; starve_en = 1'b1;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done("backpressure", 3000);
        check_frame_end("backpressure");
        tready_rand = 1'b0; starve_en = 1'b0;

        // Short result: tlast on beat 5, stale tail still sent.
        tl_idx = 5; n_out = 6;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done("short", 3000);
        check_frame_end("short");

        // Next start clears the error flag.
        tl_idx = N - 1; n_out = N;
        push_frame(1'b0);
        pulse_start(1'b0);
        chk("err_cleared_by_start", o_err_len, 1'b0);
        wait_done("after_short", 3000);
        check_frame_end("after_short");

        // Result without tlast, two surplus beats discarded.
        tl_idx = 99; n_out = N + 2;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done("no_tlast", 3000);
        check_frame_end("no_tlast");

        // Minimal busy window, exercises the start spacing guard.
        tl_idx = N - 1; n_out = N; busy_len = 1; tready_rand = 1'b1;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done("short_busy", 3000);
        check_frame_end("short_busy");
        busy_len = 10; tready_rand = 1'b0;

        // Continuous mode, stop during the third frame's payload.
        apply_reset();
        push_frame(1'b0);
        push_frame(1'b0);
        push_frame(1'b0);
        base = uart_seen;
        pulse_start(1'b1);
        wait_bytes(base + 2 * PKT + 10, 6000);
        @(negedge clk);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        wait_done("continuous", 3000);
        check_frame_end("continuous");
        chk("continuous_three_frames", o_frame_cnt, 8'd3);
        chk("continuous_bytes", uart_seen - base, 3 * PKT);
        i_continuous = 1'b0;

        // Reset in the middle of a payload, then a clean packet.
        push_frame(1'b0);
        base = uart_seen;
        pulse_start(1'b0);
        wait_bytes(base + 20, 3000);
        apply_reset();
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done("post_reset", 3000);
        check_frame_end("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
